// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames one byte (5-8 data bits, optional parity, 1/2 stop) onto TXD at a programmable baud divisor.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN (adds input i_break).
module uart_tx_serializer #(
    parameter int   DIV_W      = 16,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_din_8b,
    input  logic             i_din_valid,
    output logic             o_tx_busy,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic [1:0]       i_data_len,
    input  logic             i_stop_2b,
    input  logic             i_parity_en,
    input  logic [1:0]       i_parity_mode,
`ifdef UART_TX_BREAK_EN
    input  logic             i_break,
`endif
    output logic             o_txd,
    output logic             o_frame_done,
    output logic             o_overrun
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]       state_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_m1_reg;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_idx_reg;
    logic [2:0]       last_idx_reg;
    logic             parity_en_reg;
    logic             parity_bit_reg;
    logic             stop_2b_reg;
    logic             stop_left_reg;
    logic             txd_reg;
    logic             overrun_reg;

    logic [7:0]       len_mask;
    logic [7:0]       masked_data;
    logic             parity_load;
    logic [DIV_W-1:0] div_m1_load;
    logic             break_hold;
    logic             accept;
    logic             bit_end;

    // Data bits at or above the selected length never reach the line or the parity.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_len_mask
            assign len_mask[gi] = (4'(gi) < (4'd5 + {2'b00, i_data_len}));
        end
    endgenerate

    assign masked_data = i_din_8b & len_mask;

    always_comb begin
        parity_load = 1'b0;
        case (i_parity_mode)
            2'd0:    parity_load = ~^masked_data;
            2'd1:    parity_load = ^masked_data;
            2'd2:    parity_load = 1'b0;
            default: parity_load = 1'b1;
        endcase
    end

    // A divisor of 0 behaves like 1: every bit still lasts one cycle.
    assign div_m1_load = (i_divisor == '0) ? '0 : i_divisor - DIV_W'(1);

`ifdef UART_TX_BREAK_EN
    logic break_reg;
    assign break_hold = i_break | break_reg;
    assign o_tx_busy  = (state_reg != ST_IDLE) | break_reg;
`else
    assign break_hold = 1'b0;
    assign o_tx_busy  = (state_reg != ST_IDLE);
`endif

    assign accept       = i_din_valid && (state_reg == ST_IDLE) && !break_hold;
    assign bit_end      = (cnt_reg == '0);
    assign o_txd        = txd_reg;
    assign o_overrun    = overrun_reg;
    assign o_frame_done = (state_reg == ST_STOP) && !stop_left_reg && bit_end;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            div_m1_reg     <= '0;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            last_idx_reg   <= '0;
            parity_en_reg  <= 1'b0;
            parity_bit_reg <= 1'b0;
            stop_2b_reg    <= 1'b0;
            stop_left_reg  <= 1'b0;
            txd_reg        <= IDLE_LEVEL;
            overrun_reg    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            break_reg      <= 1'b0;
`endif
        end else begin
            overrun_reg <= i_din_valid && !accept;
            case (state_reg)
                ST_IDLE: begin
                    txd_reg <= IDLE_LEVEL;
`ifdef UART_TX_BREAK_EN
                    // Break is only honoured between frames; the line returns to mark as it falls.
                    break_reg <= i_break;
                    if (i_break) begin
                        txd_reg <= 1'b0;
                    end
`endif
                    if (accept) begin
                        state_reg      <= ST_START;
                        txd_reg        <= 1'b0;
                        cnt_reg        <= div_m1_load;
                        div_m1_reg     <= div_m1_load;
                        shift_reg      <= i_din_8b;
                        last_idx_reg   <= 3'd4 + {1'b0, i_data_len};
                        parity_en_reg  <= i_parity_en;
                        parity_bit_reg <= parity_load;
                        stop_2b_reg    <= i_stop_2b;
                    end
                end
                default: begin
                    if (!bit_end) begin
                        cnt_reg <= cnt_reg - DIV_W'(1);
                    end else begin
                        cnt_reg <= div_m1_reg;
                        case (state_reg)
                            ST_START: begin
                                state_reg   <= ST_DATA;
                                bit_idx_reg <= '0;
                                txd_reg     <= shift_reg[0];
                                shift_reg   <= shift_reg >> 1;
                            end
                            ST_DATA: begin
                                if (bit_idx_reg == last_idx_reg) begin
                                    if (parity_en_reg) begin
                                        state_reg <= ST_PARITY;
                                        txd_reg   <= parity_bit_reg;
                                    end else begin
                                        state_reg     <= ST_STOP;
                                        txd_reg       <= IDLE_LEVEL;
                                        stop_left_reg <= stop_2b_reg;
                                    end
                                end else begin
                                    bit_idx_reg <= bit_idx_reg + 3'd1;
                                    txd_reg     <= shift_reg[0];
                                    shift_reg   <= shift_reg >> 1;
                                end
                            end
                            ST_PARITY: begin
                                state_reg     <= ST_STOP;
                                txd_reg       <= IDLE_LEVEL;
                                stop_left_reg <= stop_2b_reg;
                            end
                            ST_STOP: begin
                                txd_reg <= IDLE_LEVEL;
                                if (stop_left_reg) begin
                                    stop_left_reg <= 1'b0;
                                end else begin
                                    state_reg <= ST_IDLE;
                                end
                            end
                            default: begin
                                state_reg <= ST_IDLE;
                                txd_reg   <= IDLE_LEVEL;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus pushes hand-computed frames, a monitor checks every line cycle.
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        valid;
    logic        busy;
    logic [15:0] divisor;
    logic [1:0]  data_len;
    logic        stop2;
    logic        par_en;
    logic [1:0]  par_mode;
    logic        txd;
    logic        fd;
    logic        ovr;
`ifdef UART_TX_BREAK_EN
    logic        brk;
`endif

    always #5 clk = ~clk;

    uart_tx_serializer #(.DIV_W(16), .IDLE_LEVEL(1'b1)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_din_8b     (din),
        .i_din_valid  (valid),
        .o_tx_busy    (busy),
        .i_divisor    (divisor),
        .i_data_len   (data_len),
        .i_stop_2b    (stop2),
        .i_parity_en  (par_en),
        .i_parity_mode(par_mode),
`ifdef UART_TX_BREAK_EN
        .i_break      (brk),
`endif
        .o_txd        (txd),
        .o_frame_done (fd),
        .o_overrun    (ovr)
    );

    typedef struct {
        logic [15:0] bits;   // bit i = i-th bit on the line, start bit first
        int          nbits;
        int          div;    // effective cycles per bit
    } frame_t;

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     mon_en = 1'b1;
    bit     mon_active = 1'b0;
    int     frame_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] bits, input int nbits, input int div);
        frame_t f;
        f.bits  = bits;
        f.nbits = nbits;
        f.div   = div;
        exp_q.push_back(f);
    endtask

    // Assumes the caller is just past a falling edge; config is scrambled after the strobe.
    task automatic send(input logic [7:0] d, input int div, input logic [1:0] len,
                        input logic s2, input logic pe, input logic [1:0] pm);
        din      = d;
        divisor  = 16'(div);
        data_len = len;
        stop2    = s2;
        par_en   = pe;
        par_mode = pm;
        valid    = 1'b1;
        @(negedge clk);
        valid    = 1'b0;
        din      = ~d;
        divisor  = 16'(div + 5);
        data_len = ~len;
        stop2    = ~s2;
        par_en   = ~pe;
        par_mode = ~pm;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !mon_active && busy === 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 2000), 32'd1);
    endtask

    // Monitor: each busy rising edge starts a frame that is checked cycle by cycle against the queue head.
    initial begin
        logic   prev;
        frame_t f;
        int     len_c, werr, first_bad, fd_err, busy_err;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && busy === 1'b1 && prev === 1'b0) begin
                mon_active = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("frame_expected", 32'd0, 32'd1);
                    prev = busy;
                end else begin
                    f = exp_q.pop_front();
                    len_c = f.nbits * f.div;
                    werr = 0; first_bad = -1; fd_err = 0; busy_err = 0;
                    for (int c = 0; c < len_c; c++) begin
                        if (c > 0) @(negedge clk);
                        if (txd !== f.bits[c / f.div]) begin
                            werr++;
                            if (first_bad < 0) first_bad = c;
                        end
                        if (busy !== 1'b1) busy_err++;
                        if (fd !== 1'(c == len_c - 1)) fd_err++;
                    end
                    @(negedge clk);
                    chk("frame_wave_errs", 32'(werr), 32'd0);
                    chk("frame_busy_len_errs", 32'(busy_err), 32'd0);
                    chk("frame_done_errs", 32'(fd_err), 32'd0);
                    chk("frame_end_busy", 32'(busy), 32'd0);
                    $display("frame %0d: %0d bits x %0d cycles, wave errors %0d (first at cycle %0d)",
                             frame_no, f.nbits, f.div, werr, first_bad);
                    frame_no++;
                    prev = busy;
                end
                mon_active = 1'b0;
            end else begin
                prev = busy;
            end
        end
    end

    initial begin
        int n;
        int errs;
        rst_n = 1'b0; valid = 1'b0; din = '0; divisor = 16'd1;
        data_len = 2'd3; stop2 = 1'b0; par_en = 1'b0; par_mode = 2'd0;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(fd), 32'd0);
        chk("rst_overrun", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || fd !== 1'b0 || ovr !== 1'b0) errs++;
        end
        chk("idle20_errs", 32'(errs), 32'd0);

        // divisor 4, 8N1, 0x55: 0 1010 1010 1 -> 40 cycles
        push(16'h02AA, 10, 4);
        send(8'h55, 4, 2'd3, 1'b0, 1'b0, 2'd0);
        chk("f1_no_overrun", 32'(ovr), 32'd0);
        wait_idle("f1_done");

        // divisor 3, 7E2, 0x83: 0 1100000 0 11 -> 33 cycles
        push(16'h0606, 11, 3);
        send(8'h83, 3, 2'd2, 1'b1, 1'b1, 2'd1);
        wait_idle("f2_done");

        // divisor 0, 5O1, 0x1F: 0 11111 0 1 -> 8 cycles
        push(16'h00BE, 8, 1);
        send(8'h1F, 0, 2'd0, 1'b0, 1'b1, 2'd0);
        wait_idle("f3_done");

        // divisor 2, 8N1, 0xA5 with a strobe while busy
        push(16'h034A, 10, 2);
        send(8'hA5, 2, 2'd3, 1'b0, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        din = 8'hFF; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("ovr_pulse", 32'(ovr), 32'd1);
        @(negedge clk);
        chk("ovr_clear", 32'(ovr), 32'd0);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("f4_busy_fall", 32'(n < 100), 32'd1);

        // First idle cycle: divisor 2, 6 bits mark parity 1 stop, 0x3C: 0 001111 1 1
        push(16'h01F8, 9, 2);
        send(8'h3C, 2, 2'd1, 1'b0, 1'b1, 2'd3);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_no_overrun", 32'(ovr), 32'd0);
        wait_idle("f5_done");

        // Abort mid-data with reset
        mon_en = 1'b0;
        send(8'hF0, 4, 2'd3, 1'b0, 1'b0, 2'd0);
        repeat (16) @(negedge clk);
        chk("abort_pre_txd", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_txd", 32'(txd), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;

        // divisor 1, 5 bits space parity 2 stop, 0x00: 0 00000 0 1 1
        push(16'h0180, 9, 1);
        send(8'h00, 1, 2'd0, 1'b1, 1'b1, 2'd2);
        wait_idle("f6_done");

`ifdef UART_TX_BREAK_EN
        mon_en = 1'b0;
        brk = 1'b1;
        @(negedge clk);
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                din = 8'h12; valid = 1'b1;
            end
            if (i == 21) begin
                valid = 1'b0;
                chk("break_overrun", 32'(ovr), 32'd1);
            end
            if (txd !== 1'b0 || busy !== 1'b1) errs++;
            @(negedge clk);
        end
        chk("break_line_errs", 32'(errs), 32'd0);
        brk = 1'b0;
        repeat (2) @(negedge clk);
        chk("break_end_txd", 32'(txd), 32'd1);
        chk("break_end_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
